// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the audio playback back-end.
//   SAMPLE_W_DEF   : default sample width (register-file audio tap R6[15:5])
//   FIFO_DEPTH_DEF : default sample buffer depth
//   CLK_DIV_8K     : clk cycles per sample period at 50 MHz / 8 kHz
//   hs_state_t     : valid/ack handshake FSM states
// ---------------------------------------------------------------------------
package audio_pkg;

    localparam int unsigned SAMPLE_W_DEF   = 11;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned CLK_DIV_8K     = 6250;

    typedef enum logic [1:0] {
        WAIT_VALID,
        WAIT_SPACE,
        ACK_HIGH
    } hs_state_t;

endpackage

// File: rtl/sample_fifo.sv
// ---------------------------------------------------------------------------
// sample_fifo
// Small synchronous FIFO holding audio samples between the processor
// handshake and the sample-rate playback logic.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write din (ignored when full)
//   din      : sample to write
//   pop      : advance head (ignored when empty)
//   dout     : current head entry (valid when !empty)
//   full     : registered, level == FIFO_DEPTH
//   empty    : registered, level == 0
//   level    : current occupancy, 0..FIFO_DEPTH
// ---------------------------------------------------------------------------
module sample_fifo #(
    parameter int unsigned SAMPLE_W   = 11,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [SAMPLE_W-1:0]           din,
    input  logic                          pop,
    output logic [SAMPLE_W-1:0]           dout,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [LVL_W-1:0]    level_nxt;
    logic                do_push;
    logic                do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        unique case ({do_push, do_pop})
            2'b10:   level_nxt = level + LVL_W'(1);
            2'b01:   level_nxt = level - LVL_W'(1);
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level_nxt;
            full  <= (level_nxt == LVL_W'(FIFO_DEPTH));
            empty <= (level_nxt == '0);
        end
    end

endmodule

// File: rtl/audio_sample_player.sv
// ---------------------------------------------------------------------------
// audio_sample_player
// Playback back-end for the processor audio path: accepts samples over a
// 4-phase valid/ack handshake, buffers them, releases one per sample period
// and renders the current sample as a PWM bitstream.
//   clk, rst      : clock, asynchronous active-high reset
//   sample_in     : sample from register-file audio tap (stable while valid)
//   sample_valid  : processor "sample ready" flag (R14 bit 0)
//   sample_ack    : registered acknowledge, drives register-file R13 flag
//   enable        : playback enable; 0 halts divider/PWM, output low
//   underrun_clr  : clears the sticky underrun flag
//   pwm_out       : registered PWM audio bitstream
//   underrun      : sticky, a sample tick found the FIFO empty
//   fifo_level    : current FIFO occupancy
// ---------------------------------------------------------------------------
module audio_sample_player
    import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_W   = SAMPLE_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned CLK_DIV    = CLK_DIV_8K
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SAMPLE_W-1:0]           sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ack,
    input  logic                          enable,
    input  logic                          underrun_clr,
    output logic                          pwm_out,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);

    hs_state_t           state;
    hs_state_t           state_nxt;
    logic                ack_nxt;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic [SAMPLE_W-1:0] fifo_head;
    logic [SAMPLE_W-1:0] cur_sample;
    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic [SAMPLE_W-1:0] pwm_cnt;

    sample_fifo #(
        .SAMPLE_W   (SAMPLE_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (sample_in),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // ---------------- handshake FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WAIT_VALID;
            sample_ack <= 1'b0;
        end else begin
            state      <= state_nxt;
            sample_ack <= ack_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_VALID: if (sample_valid) state_nxt = full ? WAIT_SPACE : ACK_HIGH;
            WAIT_SPACE: if (!full)        state_nxt = ACK_HIGH;
            ACK_HIGH:   if (!sample_valid) state_nxt = WAIT_VALID;
            default:    state_nxt = WAIT_VALID;
        endcase
    end

    // Push decisions use the registered full flag, so a same-cycle pop at
    // full only frees the slot for the following cycle.
    always_comb begin
        push = 1'b0;
        unique case (state)
            WAIT_VALID: push = sample_valid && !full;
            WAIT_SPACE: push = !full;
            default:    push = 1'b0;
        endcase
        // ack is a dedicated flop so the R13 flag never sees decode glitches.
        ack_nxt = (state_nxt == ACK_HIGH);
    end

    // ---------------- sample-rate divider ----------------
    assign tick = enable && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign pop  = tick && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (!enable || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_sample <= '0;
        end else if (pop) begin
            cur_sample <= fifo_head;
        end
    end

    // A set on an empty tick wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun <= 1'b0;
        end else if (tick && empty) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

    // ---------------- PWM ----------------
    // Counter restarts on every tick so each sample period begins at count 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else if (!enable || tick) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + SAMPLE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= enable && (pwm_cnt < cur_sample);
        end
    end

endmodule

// File: tb/tb_audio_sample_player.sv
// ---------------------------------------------------------------------------
// tb_audio_sample_player
// Scoreboard bench: the stimulus process pushes every accepted sample into
// exp_q; the monitor treats each block of CLK_DIV enabled cycles as one
// sample period, compares the measured PWM high count with the expected
// sample and pops the next one (or predicts an underrun).
// ---------------------------------------------------------------------------
module tb_audio_sample_player;

    localparam int unsigned SW      = 11;
    localparam int unsigned DEPTH   = 4;
    localparam int          CLK_DIV = 2048;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] sample_in;
    logic          sample_valid;
    logic          sample_ack;
    logic          enable;
    logic          underrun_clr;
    logic          pwm_out;
    logic          underrun;
    logic [2:0]    fifo_level;

    int            checks = 0;
    int            errors = 0;
    int            edge_cnt = 0;
    logic [SW-1:0] exp_q [$];

    audio_sample_player #(
        .SAMPLE_W   (SW),
        .FIFO_DEPTH (DEPTH),
        .CLK_DIV    (CLK_DIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ack   (sample_ack),
        .enable       (enable),
        .underrun_clr (underrun_clr),
        .pwm_out      (pwm_out),
        .underrun     (underrun),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic nstep(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        while (edge_cnt < target) @(negedge clk);
    endtask

    // Full 4-phase transaction; the sample enters the model once acked.
    task automatic send(input logic [SW-1:0] s, input int max_wait);
        int n;
        sample_in    = s;
        sample_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_ack && n < max_wait);
        check("ack_seen", sample_ack, 1);
        if (sample_ack) exp_q.push_back(s);
        sample_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sample_ack && n < 4);
        check("ack_release", sample_ack, 0);
    endtask

    // ---------------- monitor / reference model ----------------
    initial begin : monitor
        int            en_idx;
        int            hi;
        logic [SW-1:0] cur;
        logic          und;
        logic          tick;
        en_idx = 0;
        hi     = 0;
        cur    = '0;
        und    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                en_idx = 0;
                hi     = 0;
                cur    = '0;
                und    = 1'b0;
                exp_q.delete();
            end else begin
                tick = 1'b0;
                if (enable) begin
                    en_idx++;
                    if (pwm_out) hi++;
                    if (en_idx % CLK_DIV == 0) begin
                        check("pwm_duty", hi, int'(cur));
                        hi   = 0;
                        tick = 1'b1;
                    end
                end else begin
                    en_idx = 0;
                    hi     = 0;
                    check("pwm_idle", pwm_out, 0);
                end
                if (tick) begin
                    if (exp_q.size() == 0) und = 1'b1;
                    else cur = exp_q.pop_front();
                end else if (underrun_clr) begin
                    und = 1'b0;
                end
                check("underrun", underrun, und);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int            n;
        int            e0;
        int            t_und;
        logic [SW-1:0] s;

        rst          = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        enable       = 1'b0;
        underrun_clr = 1'b0;
        nstep(2);
        check("rst_ack", sample_ack, 0);
        check("rst_pwm", pwm_out, 0);
        check("rst_underrun", underrun, 0);
        check("rst_level", fifo_level, 0);
        rst = 1'b0;
        nstep(2);

        // single handshake
        sample_in    = 11'h400;
        sample_valid = 1'b1;
        @(negedge clk);
        check("t1_ack_rise", sample_ack, 1);
        check("t1_level", fifo_level, 1);
        exp_q.push_back(11'h400);
        sample_valid = 1'b0;
        @(negedge clk);
        check("t1_ack_fall", sample_ack, 0);
        @(negedge clk);
        check("t1_no_second_push", fifo_level, 1);

        // fill to full with playback halted
        send(11'h200, 10);
        send(11'h000, 10);
        send(11'h7FF, 10);
        check("t2_level_full", fifo_level, 4);
        s            = SW'($urandom);
        sample_in    = s;
        sample_valid = 1'b1;
        nstep(3);
        check("t2_wait_space_ack", sample_ack, 0);
        check("t2_wait_space_level", fifo_level, 4);
        enable = 1'b1;
        e0     = edge_cnt;
        n      = 0;
        while (!sample_ack && n < CLK_DIV + 50) begin
            @(negedge clk);
            n++;
            if (edge_cnt - e0 == CLK_DIV) check("t2_level_after_pop", fifo_level, 3);
        end
        check("t2_ack_after_tick", edge_cnt - e0, CLK_DIV + 1);
        check("t2_level_refill", fifo_level, 4);
        if (sample_ack) exp_q.push_back(s);
        sample_valid = 1'b0;
        @(negedge clk);
        check("t2_ack_fall", sample_ack, 0);

        // drain, underrun and clear priority
        n = 0;
        while (!underrun && n < 7 * CLK_DIV) begin
            @(negedge clk);
            n++;
        end
        check("t4_underrun_set", underrun, 1);
        t_und = edge_cnt;
        check("t4_underrun_time", t_und - e0, 6 * CLK_DIV);
        check("t4_level_empty", fifo_level, 0);
        nstep(5);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        check("t4_underrun_clr", underrun, 0);
        wait_until(t_und + CLK_DIV - 1);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        check("t4_clr_vs_set", underrun, 1);

        // push coinciding with a tick pop at level 2
        send(11'h011, 10);
        send(11'h022, 10);
        check("t5_level2", fifo_level, 2);
        wait_until(t_und + 2 * CLK_DIV - 1);
        sample_in    = 11'h033;
        sample_valid = 1'b1;
        @(negedge clk);
        check("t5_ack", sample_ack, 1);
        check("t5_level_same", fifo_level, 2);
        if (sample_ack) exp_q.push_back(11'h033);
        sample_valid = 1'b0;
        @(negedge clk);
        check("t5_ack_fall", sample_ack, 0);
        wait_until(t_und + 5 * CLK_DIV + 1);

        // reset in the middle of ACK_HIGH with level 3
        enable = 1'b0;
        @(negedge clk);
        send(SW'($urandom), 10);
        send(SW'($urandom), 10);
        check("t6_level2", fifo_level, 2);
        s            = SW'($urandom);
        sample_in    = s;
        sample_valid = 1'b1;
        @(negedge clk);
        check("t6_ack_high", sample_ack, 1);
        check("t6_level3", fifo_level, 3);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_ack", sample_ack, 0);
        check("t6_rst_pwm", pwm_out, 0);
        check("t6_rst_level", fifo_level, 0);
        check("t6_rst_underrun", underrun, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_post_rst_ack", sample_ack, 1);
        check("t6_post_rst_level", fifo_level, 1);
        if (sample_ack) exp_q.push_back(s);
        sample_valid = 1'b0;
        @(negedge clk);
        check("t6_post_rst_ack_fall", sample_ack, 0);

        // randomized playback stream
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(SW'($urandom), 3 * CLK_DIV);
            nstep($urandom_range(0, 20));
        end
        n = 0;
        while (fifo_level != 0 && n < 6 * CLK_DIV) begin
            @(negedge clk);
            n++;
        end
        check("rand_drained", fifo_level, 0);
        nstep(2 * CLK_DIV + 10);
        enable = 1'b0;
        nstep(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
